motion_bbox_detect: RTL and testbench

- Streaming frame-difference motion detector on the cam_pclk domain.
- Sits between the capture/gray stage and the SDRAM/LCD ports.
- Takes the current-frame gray pixel plus the co-located previous-frame pixel (from SDRAM read port 1), emits a binary motion mask pixel stream, and latches a per-frame bounding box and motion pixel count.
- Parametrised successor to the fixed 640x480 8-bit motion path: pixel width, image size and counter width are generic, and threshold/min-count are runtime inputs.

---
 rtl/motion_bbox_detect.sv | 270 +++++++++++++++++++++++++++
 tb/tb_motion_bbox_detect.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_bbox_detect.sv
// motion_bbox_detect
// Streaming frame-difference motion detector on the pixel clock domain.
// Each cycle it takes a current-frame gray pixel and the co-located
// previous-frame pixel. It produces a binary motion mask stream two cycles
// later, and once per frame it latches the motion bounding box and the
// motion pixel count.
//
// Ports:
//   clk, rst                       pixel clock, synchronous active-high reset
//   threshold, min_count           runtime motion threshold and minimum count,
//                                  sampled at the start of each frame
//   in_vsync, in_href, in_clken    input sync / line valid / pixel valid
//   cur_data, prev_data            current and previous frame pixel
//   post_vsync/href/clken          input syncs delayed by two cycles
//   post_bit                       motion mask pixel (|cur-prev| > threshold)
//   post_data                      delayed cur_data (optionally with box outline)
//   box_x0/x1, box_y0/y1           latched inclusive box bounds (0 if no motion)
//   motion_cnt                     latched motion pixel count
//   box_valid, motion_flag         latched count != 0, count >= min_count
//   frame_done                     one-cycle pulse when latched outputs update
//
// Optional feature macro: MOTION_OVERLAY_EN draws the latched box outline
// into post_data using OVERLAY_VAL.
module motion_bbox_detect #(
    parameter int DATA_W = 8,
    parameter int IMG_H  = 640,
    parameter int IMG_V  = 480,
    parameter int CNT_W  = 19,
    parameter logic [DATA_W-1:0] OVERLAY_VAL = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          threshold,
    input  logic [CNT_W-1:0]           min_count,
    input  logic                       in_vsync,
    input  logic                       in_href,
    input  logic                       in_clken,
    input  logic [DATA_W-1:0]          cur_data,
    input  logic [DATA_W-1:0]          prev_data,
    output logic                       post_vsync,
    output logic                       post_href,
    output logic                       post_clken,
    output logic                       post_bit,
    output logic [DATA_W-1:0]          post_data,
    output logic [$clog2(IMG_H)-1:0]   box_x0,
    output logic [$clog2(IMG_H)-1:0]   box_x1,
    output logic [$clog2(IMG_V)-1:0]   box_y0,
    output logic [$clog2(IMG_V)-1:0]   box_y1,
    output logic [CNT_W-1:0]           motion_cnt,
    output logic                       box_valid,
    output logic                       motion_flag,
    output logic                       frame_done
);

    localparam int X_W  = $clog2(IMG_H);
    localparam int Y_W  = $clog2(IMG_V);
    // Coordinate counters need one extra code to represent the saturated
    // "past the end of the line/frame" value.
    localparam int XC_W = $clog2(IMG_H + 1);
    localparam int YC_W = $clog2(IMG_V + 1);
    localparam logic [XC_W-1:0]  X_LIM  = XC_W'(IMG_H);
    localparam logic [YC_W-1:0]  Y_LIM  = YC_W'(IMG_V);
    localparam logic [X_W-1:0]   X_INIT = X_W'(IMG_H - 1);
    localparam logic [Y_W-1:0]   Y_INIT = Y_W'(IMG_V - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_WAIT, S_FRAME, S_LATCH} state_t;

    state_t state_q, state_d;

    logic              vs_prev_q, vs_prev_d, href_prev_q, href_prev_d;
    logic [XC_W-1:0]   x_q, x_d, s1_x_q, s1_x_d, s2_x_q, s2_x_d;
    logic [YC_W-1:0]   y_q, y_d, s1_y_q, s1_y_d, s2_y_q, s2_y_d;
    logic              s1_vsync_q, s1_vsync_d, s1_href_q, s1_href_d, s1_clken_q, s1_clken_d;
    logic [DATA_W-1:0] s1_diff_q, s1_diff_d, s1_data_q, s1_data_d;
    logic              post_vsync_q, post_vsync_d, post_href_q, post_href_d;
    logic              post_clken_q, post_clken_d, post_bit_q, post_bit_d, pv_prev_q, pv_prev_d;
    logic [DATA_W-1:0] post_data_q, post_data_d, thr_s_q, thr_s_d;
    logic [CNT_W-1:0]  min_s_q, min_s_d, acnt_q, acnt_d, motion_cnt_q, motion_cnt_d;
    logic [X_W-1:0]    ax0_q, ax0_d, ax1_q, ax1_d, box_x0_q, box_x0_d, box_x1_q, box_x1_d;
    logic [Y_W-1:0]    ay0_q, ay0_d, ay1_q, ay1_d, box_y0_q, box_y0_d, box_y1_q, box_y1_d;
    logic              box_valid_q, box_valid_d, motion_flag_q, motion_flag_d;
    logic              frame_done_q, frame_done_d;

    logic              vs_rise, href_fall, pv_rise, pix_hit, overlay_hit;
    logic              acc_en, acc_init, latch_en, sample_en;
    logic [DATA_W:0]   diff_ext;
    logic [X_W-1:0]    s2_px;
    logic [Y_W-1:0]    s2_py;

    // Pixel coordinates: x counts accepted pixels within a line, y counts
    // completed lines. Both saturate one past the image so that overlong
    // lines or frames never alias back into the box.
    always_comb begin
        vs_rise     = in_vsync & ~vs_prev_q;
        href_fall   = ~in_href & href_prev_q;
        vs_prev_d   = in_vsync;
        href_prev_d = in_href;
        x_d = x_q;
        y_d = y_q;
        if (vs_rise) begin
            x_d = '0;
            y_d = '0;
        end else if (href_fall) begin
            x_d = '0;
            if (y_q != Y_LIM) y_d = y_q + YC_W'(1);
        end else if (in_clken && in_href && (x_q != X_LIM)) begin
            x_d = x_q + XC_W'(1);
        end
    end

    // Two-stage pixel pipeline. The absolute difference is taken in
    // DATA_W+1 bits so that the sign is visible; only the low DATA_W bits
    // are needed for the magnitude because |diff| never exceeds 2^DATA_W-1.
    always_comb begin
        diff_ext     = {1'b0, cur_data} - {1'b0, prev_data};
        s1_diff_d    = diff_ext[DATA_W] ? (~diff_ext[DATA_W-1:0] + 1'b1) : diff_ext[DATA_W-1:0];
        s1_data_d    = cur_data;
        s1_x_d       = x_q;
        s1_y_d       = y_q;
        s1_vsync_d   = in_vsync;
        s1_href_d    = in_href;
        s1_clken_d   = in_clken;
        post_vsync_d = s1_vsync_q;
        post_href_d  = s1_href_q;
        post_clken_d = s1_clken_q;
        post_bit_d   = s1_clken_q & (s1_diff_q > thr_s_q);
        post_data_d  = overlay_hit ? OVERLAY_VAL : s1_data_q;
        s2_x_d       = s1_x_q;
        s2_y_d       = s1_y_q;
        pv_prev_d    = post_vsync_q;
        pv_rise      = post_vsync_q & ~pv_prev_q;
    end

`ifdef MOTION_OVERLAY_EN
    // The outline is drawn against the box latched from the previous frame,
    // evaluated on the coordinate that is about to enter stage 2.
    always_comb begin
        logic in_x, in_y, on_col, on_row;
        in_x   = (s1_x_q >= XC_W'(box_x0_q)) && (s1_x_q <= XC_W'(box_x1_q));
        in_y   = (s1_y_q >= YC_W'(box_y0_q)) && (s1_y_q <= YC_W'(box_y1_q));
        on_col = (s1_x_q == XC_W'(box_x0_q)) || (s1_x_q == XC_W'(box_x1_q));
        on_row = (s1_y_q == YC_W'(box_y0_q)) || (s1_y_q == YC_W'(box_y1_q));
        overlay_hit = box_valid_q && ((on_col && in_y) || (on_row && in_x));
    end
`else
    assign overlay_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_WAIT;
        else     state_q <= state_d;
    end

    // FSM next state: frames are delimited by the vsync edge seen at the
    // pipeline output so that the last pixels of a frame are counted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (pv_rise) state_d = S_FRAME;
            S_FRAME: if (pv_rise) state_d = S_LATCH;
            S_LATCH: state_d = S_FRAME;
            default: state_d = S_WAIT;
        endcase
    end

    // FSM outputs. The runtime settings are captured on every entry into
    // S_FRAME so they stay constant for a whole frame.
    always_comb begin
        acc_en    = (state_q == S_FRAME) || (state_q == S_LATCH);
        acc_init  = (state_q == S_LATCH);
        latch_en  = (state_q == S_LATCH);
        sample_en = ((state_q == S_WAIT) && pv_rise) || (state_q == S_LATCH);
    end

    // Bounding-box accumulators. In S_LATCH they restart from their init
    // values, and a motion pixel arriving in that same cycle is counted
    // toward the new frame rather than dropped.
    always_comb begin
        s2_px   = s2_x_q[X_W-1:0];
        s2_py   = s2_y_q[Y_W-1:0];
        pix_hit = post_bit_q && (s2_x_q < X_LIM) && (s2_y_q < Y_LIM);
        thr_s_d = sample_en ? threshold : thr_s_q;
        min_s_d = sample_en ? min_count : min_s_q;
        if (acc_init) begin
            ax0_d  = X_INIT;
            ax1_d  = '0;
            ay0_d  = Y_INIT;
            ay1_d  = '0;
            acnt_d = '0;
        end else begin
            ax0_d  = ax0_q;
            ax1_d  = ax1_q;
            ay0_d  = ay0_q;
            ay1_d  = ay1_q;
            acnt_d = acnt_q;
        end
        if (acc_en && pix_hit) begin
            if (s2_px < ax0_d) ax0_d = s2_px;
            if (s2_px > ax1_d) ax1_d = s2_px;
            if (s2_py < ay0_d) ay0_d = s2_py;
            if (s2_py > ay1_d) ay1_d = s2_py;
            if (acnt_d != CNT_MAX) acnt_d = acnt_d + 1'b1;
        end
    end

    // Latched per-frame results; an empty frame reports a zero box.
    always_comb begin
        box_x0_d      = box_x0_q;
        box_x1_d      = box_x1_q;
        box_y0_d      = box_y0_q;
        box_y1_d      = box_y1_q;
        motion_cnt_d  = motion_cnt_q;
        box_valid_d   = box_valid_q;
        motion_flag_d = motion_flag_q;
        frame_done_d  = latch_en;
        if (latch_en) begin
            box_valid_d   = (acnt_q != '0);
            motion_cnt_d  = acnt_q;
            motion_flag_d = (acnt_q >= min_s_q);
            box_x0_d      = (acnt_q != '0) ? ax0_q : '0;
            box_x1_d      = (acnt_q != '0) ? ax1_q : '0;
            box_y0_d      = (acnt_q != '0) ? ay0_q : '0;
            box_y1_d      = (acnt_q != '0) ? ay1_q : '0;
        end
    end

    // Datapath registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q <= 1'b0;  href_prev_q <= 1'b0;  x_q <= '0;  y_q <= '0;
            s1_vsync_q <= 1'b0; s1_href_q <= 1'b0; s1_clken_q <= 1'b0;
            s1_diff_q <= '0;  s1_data_q <= '0;  s1_x_q <= '0;  s1_y_q <= '0;
            post_vsync_q <= 1'b0; post_href_q <= 1'b0; post_clken_q <= 1'b0;
            post_bit_q <= 1'b0;  post_data_q <= '0;  s2_x_q <= '0;  s2_y_q <= '0;
            pv_prev_q <= 1'b0;  thr_s_q <= '0;  min_s_q <= '0;
            ax0_q <= X_INIT;  ax1_q <= '0;  ay0_q <= Y_INIT;  ay1_q <= '0;  acnt_q <= '0;
            box_x0_q <= '0;  box_x1_q <= '0;  box_y0_q <= '0;  box_y1_q <= '0;
            motion_cnt_q <= '0;  box_valid_q <= 1'b0;  motion_flag_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            vs_prev_q <= vs_prev_d;  href_prev_q <= href_prev_d;  x_q <= x_d;  y_q <= y_d;
            s1_vsync_q <= s1_vsync_d; s1_href_q <= s1_href_d; s1_clken_q <= s1_clken_d;
            s1_diff_q <= s1_diff_d;  s1_data_q <= s1_data_d;  s1_x_q <= s1_x_d;  s1_y_q <= s1_y_d;
            post_vsync_q <= post_vsync_d; post_href_q <= post_href_d; post_clken_q <= post_clken_d;
            post_bit_q <= post_bit_d;  post_data_q <= post_data_d;  s2_x_q <= s2_x_d;  s2_y_q <= s2_y_d;
            pv_prev_q <= pv_prev_d;  thr_s_q <= thr_s_d;  min_s_q <= min_s_d;
            ax0_q <= ax0_d;  ax1_q <= ax1_d;  ay0_q <= ay0_d;  ay1_q <= ay1_d;  acnt_q <= acnt_d;
            box_x0_q <= box_x0_d;  box_x1_q <= box_x1_d;  box_y0_q <= box_y0_d;  box_y1_q <= box_y1_d;
            motion_cnt_q <= motion_cnt_d;  box_valid_q <= box_valid_d;  motion_flag_q <= motion_flag_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign post_vsync  = post_vsync_q;
    assign post_href   = post_href_q;
    assign post_clken  = post_clken_q;
    assign post_bit    = post_bit_q;
    assign post_data   = post_data_q;
    assign box_x0      = box_x0_q;
    assign box_x1      = box_x1_q;
    assign box_y0      = box_y0_q;
    assign box_y1      = box_y1_q;
    assign motion_cnt  = motion_cnt_q;
    assign box_valid   = box_valid_q;
    assign motion_flag = motion_flag_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_motion_bbox_detect.sv
// tb_motion_bbox_detect
// Scoreboard bench for motion_bbox_detect on a small 8x4 image.
// Every driven pixel pushes its expected mask bit / data; every vsync pushes
// the expected frame summary. A monitor pops and compares on post_clken and
// on frame_done.
module tb_motion_bbox_detect;

    localparam int DATA_W = 8;
    localparam int IMG_H  = 8;
    localparam int IMG_V  = 4;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] threshold;
    logic [CNT_W-1:0]  min_count;
    logic              in_vsync, in_href, in_clken;
    logic [DATA_W-1:0] cur_data, prev_data;
    logic              post_vsync, post_href, post_clken, post_bit;
    logic [DATA_W-1:0] post_data;
    logic [2:0]        box_x0, box_x1;
    logic [1:0]        box_y0, box_y1;
    logic [CNT_W-1:0]  motion_cnt;
    logic              box_valid, motion_flag, frame_done;

    motion_bbox_detect #(
        .DATA_W(DATA_W), .IMG_H(IMG_H), .IMG_V(IMG_V), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .threshold(threshold), .min_count(min_count),
        .in_vsync(in_vsync), .in_href(in_href), .in_clken(in_clken),
        .cur_data(cur_data), .prev_data(prev_data),
        .post_vsync(post_vsync), .post_href(post_href), .post_clken(post_clken),
        .post_bit(post_bit), .post_data(post_data),
        .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
        .motion_cnt(motion_cnt), .box_valid(box_valid),
        .motion_flag(motion_flag), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bitv;
        logic [7:0] data;
        int         stamp;
    } pix_t;

    typedef struct {
        int   cnt;
        logic valid;
        logic flag;
        int   x0, x1, y0, y1;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int   cur_img [IMG_V][IMG_H];
    int   prev_img[IMG_V][IMG_H];

    // Reference model state: settings of the running frame, its accumulators
    // and the box latched from the previous frame (used for the overlay).
    bit   m_active;
    int   m_thr, m_min, m_cnt, m_x0, m_x1, m_y0, m_y1;
    bit   lat_valid;
    int   lx0, lx1, ly0, ly1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT should produce.
    task automatic applyStimulus(input bit vs, input bit hr, input bit ck,
                                 input int cur, input int prev, input int x, input int y);
        pix_t p;
        int   d;
        bit   perim;
        in_vsync  = vs;
        in_href   = hr;
        in_clken  = ck;
        cur_data  = cur[7:0];
        prev_data = prev[7:0];
        if (hr && ck) begin
            d = cur - prev;
            if (d < 0) d = -d;
            p.bitv  = (d > m_thr);
            p.data  = cur[7:0];
            p.stamp = cyc;
            perim = lat_valid &&
                    (((x == lx0 || x == lx1) && y >= ly0 && y <= ly1) ||
                     ((y == ly0 || y == ly1) && x >= lx0 && x <= lx1));
`ifdef MOTION_OVERLAY_EN
            if (perim) p.data = 8'hFF;
`else
            if (perim) p.data = cur[7:0];
`endif
            pix_q.push_back(p);
            if (m_active && p.bitv && x < IMG_H && y < IMG_V) begin
                m_cnt++;
                if (x < m_x0) m_x0 = x;
                if (x > m_x1) m_x1 = x;
                if (y < m_y0) m_y0 = y;
                if (y > m_y1) m_y1 = y;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clearAcc();
        m_cnt = 0;
        m_x0 = IMG_H - 1;  m_x1 = 0;
        m_y0 = IMG_V - 1;  m_y1 = 0;
    endtask

    // Frame boundary: close the running frame in the model, then start a new
    // one with the settings presented right now.
    task automatic sendVsync();
        frm_t f;
        if (m_active) begin
            f.cnt   = m_cnt;
            f.valid = (m_cnt != 0);
            f.flag  = (m_cnt >= m_min);
            f.x0    = f.valid ? m_x0 : 0;
            f.x1    = f.valid ? m_x1 : 0;
            f.y0    = f.valid ? m_y0 : 0;
            f.y1    = f.valid ? m_y1 : 0;
            frm_q.push_back(f);
            lat_valid = f.valid;
            lx0 = f.x0;  lx1 = f.x1;  ly0 = f.y0;  ly1 = f.y1;
        end
        m_active = 1;
        m_thr    = threshold;
        m_min    = min_count;
        clearAcc();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fillStill();
        for (int y = 0; y < IMG_V; y++)
            for (int x = 0; x < IMG_H; x++) begin
                cur_img[y][x]  = (x * 13 + y * 29 + 7) % 256;
                prev_img[y][x] = cur_img[y][x];
            end
    endtask

    task automatic setPix(input int x, input int y, input int c, input int p);
        cur_img[y][x]  = c;
        prev_img[y][x] = p;
    endtask

    // Odd lines insert a clken-low cycle after each pixel; 'extra' appends an
    // out-of-range motion pixel to the last line driven.
    task automatic runLines(input int y_start, input int y_end, input bit extra);
        for (int y = y_start; y <= y_end; y++) begin
            for (int x = 0; x < IMG_H; x++) begin
                applyStimulus(0, 1, 1, cur_img[y][x], prev_img[y][x], x, y);
                if (y % 2 == 1) applyStimulus(0, 1, 0, 0, 0, x, y);
            end
            if (extra && y == y_end) applyStimulus(0, 1, 1, 100, 50, IMG_H, y);
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_cnt"},   motion_cnt,  0);
        checkOutput({tag, "_valid"}, box_valid,   0);
        checkOutput({tag, "_flag"},  motion_flag, 0);
        checkOutput({tag, "_done"},  frame_done,  0);
        checkOutput({tag, "_x0"},    box_x0,      0);
        checkOutput({tag, "_x1"},    box_x1,      0);
        checkOutput({tag, "_y0"},    box_y0,      0);
        checkOutput({tag, "_y1"},    box_y1,      0);
        checkOutput({tag, "_bit"},   post_bit,    0);
        checkOutput({tag, "_ck"},    post_clken,  0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix_q.delete();
        m_active  = 0;
        lat_valid = 0;
        clearAcc();
    endtask

    // Monitor: compare DUT output events against the scoreboard queues.
    always @(negedge clk) begin
        pix_t p;
        frm_t f;
        if (!rst) begin
            if (post_clken) begin
                if (pix_q.size() == 0) checkOutput("pix_unexpected", 1, 0);
                else begin
                    p = pix_q.pop_front();
                    checkOutput("post_bit", post_bit, p.bitv);
                    checkOutput("post_data", post_data, p.data);
                    checkOutput("latency", cyc - p.stamp, 2);
                    checkOutput("post_href", post_href, 1);
                end
            end
            if (frame_done) begin
                if (frm_q.size() == 0) checkOutput("frame_unexpected", 1, 0);
                else begin
                    f = frm_q.pop_front();
                    checkOutput("motion_cnt", motion_cnt, f.cnt);
                    checkOutput("box_valid", box_valid, f.valid);
                    checkOutput("motion_flag", motion_flag, f.flag);
                    checkOutput("box_x0", box_x0, f.x0);
                    checkOutput("box_x1", box_x1, f.x1);
                    checkOutput("box_y0", box_y0, f.y0);
                    checkOutput("box_y1", box_y1, f.y1);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1;  threshold = 8'd20;  min_count = 6'd2;
        in_vsync = 0;  in_href = 0;  in_clken = 0;  cur_data = 0;  prev_data = 0;
        m_active = 0;  lat_valid = 0;  m_thr = 0;  m_min = 0;
        clearAcc();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkCleared("reset");

        $display("[TB] first vsync: no frame_done expected");
        sendVsync();

        $display("[TB] still frame");
        fillStill();
        runLines(0, 3, 0);
        sendVsync();

        $display("[TB] two motion pixels");
        fillStill();
        setPix(2, 1, 100, 50);
        setPix(5, 3, 100, 50);
        runLines(0, 3, 0);
        sendVsync();

        $display("[TB] threshold boundary, threshold change mid-frame");
        fillStill();
        setPix(0, 0, 70, 50);
        setPix(1, 0, 50, 71);
        setPix(7, 2, 0, 255);
        runLines(0, 1, 0);
        threshold = 8'd255;
        runLines(2, 3, 0);
        sendVsync();

        $display("[TB] frame under threshold 255");
        fillStill();
        setPix(2, 1, 100, 50);
        setPix(5, 3, 100, 50);
        setPix(3, 3, 0, 255);
        runLines(0, 3, 0);
        threshold = 8'd20;
        sendVsync();

        $display("[TB] motion frame before reset");
        fillStill();
        setPix(6, 0, 200, 10);
        setPix(4, 2, 10, 200);
        runLines(0, 3, 0);
        sendVsync();

        $display("[TB] reset mid-frame");
        fillStill();
        setPix(1, 1, 100, 50);
        runLines(0, 1, 0);
        checkOutput("pre_reset_cnt", motion_cnt, 2);
        pulseReset();
        checkCleared("midreset");
        sendVsync();

        $display("[TB] frame after reset with out-of-range pixel");
        fillStill();
        setPix(0, 0, 100, 50);
        setPix(7, 3, 100, 50);
        runLines(0, 3, 1);
        min_count = 6'd0;
        sendVsync();

        $display("[TB] frame without href");
        sendVsync();

        wait_cyc = 0;
        while ((frm_q.size() != 0 || pix_q.size() != 0) && wait_cyc < 50) begin
            @(posedge clk);
            wait_cyc++;
        end
        #1;
        checkOutput("drain_frames", frm_q.size(), 0);
        checkOutput("drain_pixels", pix_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("hold_valid", box_valid, 0);
        checkOutput("hold_flag", motion_flag, 1);
        checkOutput("hold_done", frame_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
